wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-back side driver for the register file's write port in the three-stage pipeline. It merges single-cycle execute results with variable-latency load responses into one registered stream (`reg_wr`, `waddr`, `wdata`) that is applied on the register file's negedge write. A 32-bit scoreboard tracks registers with loads in flight and raises a decode-stage hazard stall for them. It also enforces fairness so buffered loads are never starved by execute traffic.

## Interface
- `DATA_W`, 32: data width.
- `FIFO_DEPTH`, 2: load-response buffer entries (power of two).
- `STARVE_MAX`, 4: consecutive cycles a non-empty FIFO may lose arbitration before execute is held.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ex_valid`  in  1  execute result present.
- `ex_ready`  out  1  execute result accepted this cycle.
- `ex_rd`  in  5  execute destination.
- `ex_data`  in  DATA_W  execute result.
- `ld_issue`  in  1  load issued this cycle.
- `ld_issue_rd`  in  5  issued load destination.
- `ld_resp_valid`  in  1  load response present.
- `ld_resp_ready`  out  1  response accepted, equal to FIFO not full.
- `ld_resp_rd`  in  5  response destination.
- `ld_resp_data`  in  DATA_W  response data.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  decode-stage operands.
- `hazard_stall`  out  1  decode must stall.
- `reg_wr`  out  1  register-file write enable, registered.
- `waddr`  out  5  register-file write address, registered.
- `wdata`  out  DATA_W  register-file write data, registered.

## Operation
- **Reset.**
  - `reg_wr`=0, `waddr`=0, `wdata`=0.
  - FIFO empty, scoreboard all 0, starvation counter 0.
  - `ex_ready`=1, `ld_resp_ready`=1, `hazard_stall`=0.
  - Reset mid-operation discards FIFO contents and pending bits.
- **Scoreboard.**
  - `ld_issue` with `ld_issue_rd`≠0 sets `pending[rd]` at the edge.
  - `pending[rd]` clears at the edge where that load's FIFO entry is selected for write.
  - Set and clear of the same index at the same edge: set wins.
  - Issue to an already-pending rd is illegal. The bit stays set and no error is flagged.
- **Hazard.** `hazard_stall` = `pending[dec_rs1]` | `pending[dec_rs2]` | `pending[dec_rd]`. It is combinational, and index 0 never counts.
- **FIFO.**
  - A load response is written when `ld_resp_valid` & `ld_resp_ready`.
  - A simultaneous push and pop while full is not possible, because ready is computed from the pre-pop state.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Arbitration, each cycle.**
  - `ex_ready` = !(counter == `STARVE_MAX`).
  - If `ex_valid` & `ex_ready`, the execute result wins. The FIFO head is held, and the counter increments if the FIFO is non-empty.
  - Otherwise, if the FIFO is non-empty, the head pops and the counter clears.
  - Otherwise there is no write.
  - An empty FIFO holds the counter at 0.
- **x0 handling.** A selected entry with rd=0 (from execute or a load) is consumed, but the next-cycle `reg_wr` is 0. `waddr`/`wdata` still update.
- **Output register.** The selected rd/data are latched at the edge. `reg_wr`=1 for exactly one cycle per non-x0 selection.

## Timing
- **Execute to write.** `ex_valid` accepted in cycle N gives `reg_wr`=1 in cycle N+1. The register file writes on the negedge of N+1.
- **Load to write.** A response accepted in cycle N is at the FIFO head in N+1 and gives the earliest `reg_wr` in N+2.
- **Stall release.** `hazard_stall` for that rd drops in the same cycle `reg_wr` is high. A decode read in that cycle sees the new value via the negedge write.
- **Worst-case load wait** with continuous execute traffic: `STARVE_MAX`+1 cycles after reaching the head.
- `ex_ready` and `ld_resp_ready` depend only on registered state. There are no combinational paths from valid to ready.

## Test plan
- **Execute write.** `ex_valid`=1, rd=5, data=0xDEADBEEF in cycle 0 -> cycle 1: `reg_wr`=1, `waddr`=5, `wdata`=0xDEADBEEF. Cycle 2: `reg_wr`=0.
- **Load scoreboard.** `ld_issue` rd=7 at cycle 0, then `dec_rs1`=7 -> `hazard_stall`=1. Response rd=7, data=0x1234 at cycle 3 -> `reg_wr`/`waddr`=7 at cycle 5, and `hazard_stall`=0 in cycle 5.
- **Starvation.** FIFO holds one entry, rd=9, while `ex_valid`=1 continuously with rd=1 -> 4 execute writes, then `ex_ready`=0 for one cycle, the rd=9 write follows, and `ex_ready` returns to 1.
- **Backpressure.** Two load responses with `ex_valid` held high -> `ld_resp_ready`=0 when the FIFO is full. It returns to 1 the cycle after a pop, and entries are written in arrival order.
- **x0 writes.** Execute rd=0 and load response rd=0 -> both consumed, `reg_wr` never asserts, and no scoreboard bit changes.
- **Reset mid-operation.** Assert `rst_n`=0 while the FIFO holds 2 entries and 3 pending bits are set -> all outputs 0 immediately (asynchronously) and `hazard_stall`=0. After release, no stale writes occur.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Drives the register file's write port in the write-back stage. Single-cycle
//   execute results and variable-latency load responses are merged into one
//   registered write stream (reg_wr/waddr/wdata). The register file applies
//   that write on the falling edge of the same cycle.
//   A 32-entry scoreboard tracks destinations that have a load in flight and
//   stalls decode on them. A starvation counter makes sure buffered load
//   responses are never locked out by back-to-back execute results.
//
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   ex_valid/ex_ready          execute result handshake (ready is state-only)
//   ex_rd, ex_data             execute destination / result
//   ld_issue, ld_issue_rd      load issued this cycle and its destination
//   ld_resp_valid/ready        load response handshake (ready = buffer not full)
//   ld_resp_rd, ld_resp_data   load response destination / data
//   dec_rs1, dec_rs2, dec_rd   decode-stage register operands
//   hazard_stall               decode must stall (combinational)
//   reg_wr, waddr, wdata       registered register-file write port
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,   // power of two, >= 2
  parameter int STARVE_MAX = 4    // >= 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ld_issue,
  input  logic [4:0]        ld_issue_rd,
  input  logic              ld_resp_valid,
  output logic              ld_resp_ready,
  input  logic [4:0]        ld_resp_rd,
  input  logic [DATA_W-1:0] ld_resp_data,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  output logic              hazard_stall,
  output logic              reg_wr,
  output logic [4:0]        waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STARVE_LIM    = CNT_W'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // ---------------------------------------------------------------------------
  // Load-response buffer
  // ---------------------------------------------------------------------------
  wb_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  wb_entry_t        head;

  assign fifo_empty    = (fifo_cnt == '0);
  assign fifo_full     = (fifo_cnt == FIFO_FULL_CNT);
  // Taken from the pre-pop occupancy, so a full buffer never sees push+pop.
  assign ld_resp_ready = !fifo_full;
  assign push          = ld_resp_valid & ld_resp_ready;
  assign head          = fifo_mem[rd_ptr];

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rd: ld_resp_rd, data: ld_resp_data};
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration and starvation guard
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             sel_ex;

  // Execute is held off for one cycle once the buffer head has lost
  // STARVE_MAX arbitrations in a row; that cycle the head is guaranteed to pop.
  assign ex_ready = (starve_cnt != STARVE_LIM);
  assign sel_ex   = ex_valid & ex_ready;
  assign pop      = !sel_ex & !fifo_empty;

  always_comb begin
    starve_nxt = starve_cnt;
    if (fifo_empty)  starve_nxt = '0;
    else if (sel_ex) starve_nxt = starve_cnt + CNT_W'(1);  // cannot pass the limit: sel_ex implies below it
    else             starve_nxt = '0;                      // head popped
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_nxt;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard of destinations with a load in flight
  // ---------------------------------------------------------------------------
  logic [31:0] pending, pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head.rd] = 1'b0;
    // Issue applied after the clear so a same-edge set on the same index wins.
    if (ld_issue && (ld_issue_rd != 5'd0)) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // x0 is hard-wired, so it never blocks decode.
  assign hazard_stall = ((dec_rs1 != 5'd0) && pending[dec_rs1]) |
                        ((dec_rs2 != 5'd0) && pending[dec_rs2]) |
                        ((dec_rd  != 5'd0) && pending[dec_rd]);

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  wb_entry_t sel_entry;

  always_comb begin
    sel_entry = head;
    if (sel_ex) sel_entry = '{rd: ex_rd, data: ex_data};
  end

  // An x0 selection is consumed and still moves waddr/wdata, but never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else if (sel_ex || pop) begin
      reg_wr <= (sel_entry.rd != 5'd0);
      waddr  <= sel_entry.rd;
      wdata  <= sel_entry.data;
    end else begin
      reg_wr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter. Expected register-file writes are queued
// as stimulus is driven; a negedge monitor pops and compares every reg_wr.
// Cycle-exact handshake/hazard values are checked inline.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_resp_valid, ld_resp_ready;
  logic [4:0]  ld_resp_rd;
  logic [31:0] ld_resp_data;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        hazard_stall;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_resp_valid(ld_resp_valid), .ld_resp_ready(ld_resp_ready),
    .ld_resp_rd(ld_resp_rd), .ld_resp_data(ld_resp_data),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .hazard_stall(hazard_stall),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard side: every write the DUT performs must be the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_wr === 1'b1) begin
      exp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $error("FAIL unexpected_write: observed waddr=%0d wdata=%0h expected no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        assert (waddr === e.rd && wdata === e.data) else begin
          miscompares++;
          $error("FAIL write_order: observed waddr=%0d wdata=%0h expected waddr=%0d wdata=%0h",
                 waddr, wdata, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run expected completion before time limit");
    $fatal(1, "time limit reached");
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_resp_valid = 0; ld_resp_rd = 0; ld_resp_data = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;

    // ---- reset state
    #2;
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_ld_resp_ready", ld_resp_ready, 1);
    chk("rst_hazard", hazard_stall, 0);
    #10 rst_n = 1'b1;
    tick();

    // ---- execute write: accepted cycle 0, written cycle 1
    ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
    push_exp(5, 32'hDEADBEEF);
    chk("ex_ready_c0", ex_ready, 1);
    tick();
    ex_valid = 0;
    chk("ex_reg_wr_c1", reg_wr, 1);
    chk("ex_waddr_c1", waddr, 5);
    chk("ex_wdata_c1", wdata, 32'hDEADBEEF);
    tick();
    chk("ex_reg_wr_c2", reg_wr, 0);
    tick();

    // ---- load scoreboard: issue rd=7, response in cycle 3, write cycle 5
    ld_issue = 1; ld_issue_rd = 7;
    tick();                                   // c1
    ld_issue = 0; dec_rs1 = 7; #1;
    chk("ld_hazard_c1", hazard_stall, 1);
    tick();                                   // c2
    chk("ld_hazard_c2", hazard_stall, 1);
    tick();                                   // c3
    ld_resp_valid = 1; ld_resp_rd = 7; ld_resp_data = 32'h1234;
    push_exp(7, 32'h1234);
    chk("ld_resp_ready_c3", ld_resp_ready, 1);
    tick();                                   // c4
    ld_resp_valid = 0;
    chk("ld_reg_wr_c4", reg_wr, 0);
    chk("ld_hazard_c4", hazard_stall, 1);
    tick();                                   // c5
    chk("ld_reg_wr_c5", reg_wr, 1);
    chk("ld_waddr_c5", waddr, 7);
    chk("ld_hazard_c5", hazard_stall, 0);
    tick();
    chk("ld_reg_wr_c6", reg_wr, 0);
    dec_rs1 = 0;
    tick();

    // ---- starvation: one buffered entry vs continuous execute traffic
    ld_resp_valid = 1; ld_resp_rd = 9; ld_resp_data = 32'h9999;
    tick();
    ld_resp_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      ex_valid = 1; ex_rd = 1; ex_data = 32'h100 + 32'(k);
      if (k == 5) begin
        chk($sformatf("starve_ex_ready_%0d", k), ex_ready, 0);
        push_exp(9, 32'h9999);
      end else begin
        chk($sformatf("starve_ex_ready_%0d", k), ex_ready, 1);
        push_exp(1, 32'h100 + 32'(k));
      end
      tick();
    end
    ex_valid = 0;
    tick();
    tick();

    // ---- backpressure: two responses, execute held high throughout
    for (int k = 0; k <= 11; k++) begin
      logic exp_ldr;
      ex_valid = 1; ex_rd = 2; ex_data = 32'h200 + 32'(k);
      ld_resp_valid = (k <= 1);
      ld_resp_rd    = (k == 0) ? 5'd10 : 5'd11;
      ld_resp_data  = (k == 0) ? 32'hAAAA0010 : 32'hAAAA0011;
      exp_ldr = !(k >= 2 && k <= 5);
      chk($sformatf("bp_ld_resp_ready_%0d", k), ld_resp_ready, exp_ldr);
      chk($sformatf("bp_ex_ready_%0d", k), ex_ready, (k != 5 && k != 10));
      if (k == 5)       push_exp(10, 32'hAAAA0010);
      else if (k == 10) push_exp(11, 32'hAAAA0011);
      else              push_exp(2, 32'h200 + 32'(k));
      tick();
    end
    ex_valid = 0; ld_resp_valid = 0;
    tick();
    tick();

    // ---- x0: execute and load to rd=0 are consumed without a write
    ex_valid = 1; ex_rd = 0; ex_data = 32'h55;
    ld_resp_valid = 1; ld_resp_rd = 0; ld_resp_data = 32'h66;
    ld_issue = 1; ld_issue_rd = 0;
    tick();
    ex_valid = 0; ld_resp_valid = 0; ld_issue = 0;
    chk("x0_reg_wr_c1", reg_wr, 0);
    chk("x0_wdata_c1", wdata, 32'h55);
    chk("x0_waddr_c1", waddr, 0);
    tick();
    chk("x0_reg_wr_c2", reg_wr, 0);
    chk("x0_wdata_c2", wdata, 32'h66);
    chk("x0_ld_resp_ready", ld_resp_ready, 1);
    tick();

    // ---- reset mid-operation: 3 pending bits, 2 buffered entries
    ld_issue = 1; ld_issue_rd = 3;
    tick();
    ld_issue_rd = 4;
    tick();
    ld_issue_rd = 6;
    ex_valid = 1; ex_rd = 1; ex_data = 32'h300; push_exp(1, 32'h300);
    ld_resp_valid = 1; ld_resp_rd = 3; ld_resp_data = 32'h333;
    tick();
    ld_issue = 0;
    ex_data = 32'h301; push_exp(1, 32'h301);
    ld_resp_rd = 4; ld_resp_data = 32'h444;
    chk("mr_ld_resp_ready_c3", ld_resp_ready, 1);
    tick();
    ex_valid = 0; ld_resp_valid = 0;
    chk("mr_full", ld_resp_ready, 0);
    chk("mr_reg_wr_before", reg_wr, 1);
    dec_rd = 6; #1;
    chk("mr_hazard_rd", hazard_stall, 1);
    dec_rd = 0; dec_rs2 = 4; #1;
    chk("mr_hazard_rs2", hazard_stall, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    dec_rs1 = 3; dec_rs2 = 4; dec_rd = 6;
    #1;
    chk("mr_reg_wr", reg_wr, 0);
    chk("mr_waddr", waddr, 0);
    chk("mr_wdata", wdata, 0);
    chk("mr_hazard", hazard_stall, 0);
    chk("mr_ld_resp_ready", ld_resp_ready, 1);
    chk("mr_ex_ready", ex_ready, 1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mr_post_reg_wr_%0d", k), reg_wr, 0);
    end
    chk("mr_post_hazard", hazard_stall, 0);
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;

    chk("exp_queue_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
